// File: rtl/arb_requester_ctrl.sv
// arb_requester_ctrl
// ------------------
// Requester-side front end for an N-way fixed-priority arbiter. Each channel
// accepts a burst job (length in beats), raises req toward the arbiter and
// holds it until the requested number of granted beats has been transferred.
// A grant can be withdrawn at any time while a higher-priority channel runs;
// the channel simply keeps requesting and resumes when granted again.
//
// Ports:
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, active low
//   job_valid  in   N        per-channel job submit, sampled at posedge
//   job_len    in   N*LEN_W  burst length, channel i in [i*LEN_W +: LEN_W]
//   job_ready  out  N        channel idle and able to take a job
//   req        out  N        registered request vector to the arbiter
//   gnt        in   N        grant vector from the arbiter
//   beat       out  N        combinational, one granted beat this cycle
//   done       out  N        registered one-cycle pulse after the last beat
//   starve     out  N        registered, set after TIMEOUT ungranted cycles
//                            waiting for the first beat, held until next job
//   gnt_err    out  1        registered, sticky; grant protocol violation

module arb_requester_ctrl #(
    parameter int N       = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         job_valid,
    input  logic [N*LEN_W-1:0]   job_len,
    output logic [N-1:0]         job_ready,
    output logic [N-1:0]         req,
    input  logic [N-1:0]         gnt,
    output logic [N-1:0]         beat,
    output logic [N-1:0]         done,
    output logic [N-1:0]         starve,
    output logic                 gnt_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0]       WAIT_ONE  = 8'd1;
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [N-1:0]     GNT_ONE   = N'(1);

    state_e              state_q [N];
    state_e              state_d [N];
    logic [LEN_W-1:0]    rem_q   [N];
    logic [LEN_W-1:0]    rem_d   [N];
    logic [7:0]          wait_q  [N];
    logic [7:0]          wait_d  [N];

    logic [N-1:0]        req_q, req_d;
    logic [N-1:0]        done_q, done_d;
    logic [N-1:0]        starve_q, starve_d;
    logic                gnt_err_q, gnt_err_d;

    logic [N-1:0]        active;
    logic                gnt_multi;
    logic                gnt_stray;

    // A channel is active (requesting) in WAIT and XFER. Only an active
    // channel that is also granted transfers a beat; a grant landing on an
    // idle or finishing channel is a protocol error, never a beat.
    always_comb begin
        active    = '0;
        job_ready = '0;
        beat      = '0;
        for (int i = 0; i < N; i++) begin
            active[i]    = (state_q[i] == WAIT) || (state_q[i] == XFER);
            job_ready[i] = (state_q[i] == IDLE);
            beat[i]      = gnt[i] & req_q[i] & active[i];
        end
    end

    // Per-channel next-state logic. The wait counter only runs in WAIT, so
    // being preempted mid-burst in XFER never counts toward starvation.
    // starve is cleared only when a new job is accepted.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i]  = state_q[i];
            rem_d[i]    = rem_q[i];
            wait_d[i]   = wait_q[i];
            starve_d[i] = starve_q[i];
            case (state_q[i])
                IDLE: begin
                    if (job_valid[i] && (job_len[i*LEN_W +: LEN_W] != '0)) begin
                        rem_d[i]    = job_len[i*LEN_W +: LEN_W];
                        wait_d[i]   = '0;
                        starve_d[i] = 1'b0;
                        state_d[i]  = WAIT;
                    end
                end
                WAIT: begin
                    if (beat[i]) begin
                        rem_d[i]   = rem_q[i] - LEN_ONE;
                        state_d[i] = (rem_q[i] == LEN_ONE) ? DONE : XFER;
                    end else begin
                        if (wait_q[i] < TIMEOUT_C) begin
                            wait_d[i] = wait_q[i] + WAIT_ONE;
                        end
                        if (wait_q[i] >= TIMEOUT_C - WAIT_ONE) begin
                            starve_d[i] = 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (beat[i]) begin
                        rem_d[i] = rem_q[i] - LEN_ONE;
                        if (rem_q[i] == LEN_ONE) begin
                            state_d[i] = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d[i] = IDLE;
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    // Registered outputs are derived from the next state so that req and
    // done line up exactly with the state they describe.
    always_comb begin
        req_d  = '0;
        done_d = '0;
        for (int i = 0; i < N; i++) begin
            req_d[i]  = (state_d[i] == WAIT) || (state_d[i] == XFER);
            done_d[i] = (state_d[i] == DONE);
        end
    end

    // More than one grant bit (x & (x-1) clears the lowest set bit), or a
    // grant to a channel that is not currently requesting.
    always_comb begin
        gnt_multi = ((gnt & (gnt - GNT_ONE)) != '0);
        gnt_stray = ((gnt & ~req_q) != '0);
        gnt_err_d = gnt_err_q | gnt_multi | gnt_stray;
    end

    // State register; reset discards any job in flight without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                rem_q[i]   <= '0;
                wait_q[i]  <= '0;
            end
            req_q     <= '0;
            done_q    <= '0;
            starve_q  <= '0;
            gnt_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
                wait_q[i]  <= wait_d[i];
            end
            req_q     <= req_d;
            done_q    <= done_d;
            starve_q  <= starve_d;
            gnt_err_q <= gnt_err_d;
        end
    end

    assign req     = req_q;
    assign done    = done_q;
    assign starve  = starve_q;
    assign gnt_err = gnt_err_q;

endmodule

// File: tb/tb_arb_requester_ctrl.sv
// tb_arb_requester_ctrl
// ---------------------
// Directed bench for arb_requester_ctrl. A registered fixed-priority arbiter
// model (bit 0 highest) provides grants; its registered choice is gated by
// the live req vector so a channel that has just finished is never granted.
// The bench can also take over gnt directly to create protocol violations.

module tb_arb_requester_ctrl;

    localparam int N       = 4;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N-1:0]        job_valid = '0;
    logic [N*LEN_W-1:0]  job_len = '0;
    logic [N-1:0]        job_ready;
    logic [N-1:0]        req;
    logic [N-1:0]        gnt;
    logic [N-1:0]        beat;
    logic [N-1:0]        done;
    logic [N-1:0]        starve;
    logic                gnt_err;

    logic                arb_en = 1'b1;
    logic [N-1:0]        force_gnt = '0;
    logic [N-1:0]        arb_q = '0;

    int                  vectors = 0;
    int                  miscompares = 0;
    int                  beat_cnt [N] = '{default: 0};
    int                  s0, s1, s3;

    arb_requester_ctrl #(
        .N       (N),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .req       (req),
        .gnt       (gnt),
        .beat      (beat),
        .done      (done),
        .starve    (starve),
        .gnt_err   (gnt_err)
    );

    always #5 clk = ~clk;

    // Fixed priority: lowest-index requester wins.
    function automatic logic [N-1:0] prio(input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) begin
                g = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // Registered arbiter model, output gated by the current request vector.
    always @(posedge clk) begin
        arb_q <= prio(req);
    end

    assign gnt = arb_en ? (arb_q & req) : force_gnt;

    // Beat monitor: counts beats transferred at each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (beat[i]) begin
                beat_cnt[i] = beat_cnt[i] + 1;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [LEN_W-1:0] len);
        job_valid[ch] = 1'b1;
        job_len[ch*LEN_W +: LEN_W] = len;
    endtask

    task automatic clearJobs();
        job_valid = '0;
        job_len   = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset values
        #12;
        checkOutput("rst_req",       32'(req),       32'h0);
        checkOutput("rst_job_ready", 32'(job_ready), 32'hf);
        checkOutput("rst_done",      32'(done),      32'h0);
        checkOutput("rst_starve",    32'(starve),    32'h0);
        checkOutput("rst_gnt_err",   32'(gnt_err),   32'h0);
        checkOutput("rst_beat",      32'(beat),      32'h0);
        rst = 1'b1;

        // Single job ch2 len 3, uncontested
        applyStimulus(2, 3);
        step(1);
        clearJobs();
        checkOutput("t1_req",       32'(req),       32'h4);
        checkOutput("t1_job_ready", 32'(job_ready), 32'hb);
        checkOutput("t1_beat0",     32'(beat),      32'h0);
        step(1);
        checkOutput("t1_beat1",     32'(beat),      32'h4);
        step(1);
        checkOutput("t1_beat2",     32'(beat),      32'h4);
        step(1);
        checkOutput("t1_beat3",     32'(beat),      32'h4);
        checkOutput("t1_nodone",    32'(done),      32'h0);
        step(1);
        checkOutput("t1_done",      32'(done),      32'h4);
        checkOutput("t1_req_off",   32'(req),       32'h0);
        step(1);
        checkOutput("t1_done_off",  32'(done),      32'h0);
        checkOutput("t1_ready",     32'(job_ready), 32'hf);
        checkOutput("t1_beats",     32'(beat_cnt[2]), 32'd3);
        step(2);

        // ch3 len 4 and ch0 len 2 in the same cycle
        s0 = beat_cnt[0];
        s3 = beat_cnt[3];
        applyStimulus(3, 4);
        applyStimulus(0, 2);
        step(1);
        clearJobs();
        checkOutput("t2_req",       32'(req),  32'h9);
        step(3);
        checkOutput("t2_done0",     32'(done), 32'h1);
        checkOutput("t2_req3",      32'(req),  32'h8);
        checkOutput("t2_ch3_idle",  32'(beat_cnt[3] - s3), 32'd0);
        step(5);
        checkOutput("t2_done3",     32'(done), 32'h8);
        checkOutput("t2_beats0",    32'(beat_cnt[0] - s0), 32'd2);
        checkOutput("t2_beats3",    32'(beat_cnt[3] - s3), 32'd4);
        checkOutput("t2_starve",    32'(starve), 32'h0);
        step(2);

        // ch3 len 5 preempted after 2 beats by ch1 len 3
        s1 = beat_cnt[1];
        s3 = beat_cnt[3];
        applyStimulus(3, 5);
        step(1);
        clearJobs();
        step(1);
        applyStimulus(1, 3);
        step(1);
        clearJobs();
        checkOutput("t3_req",       32'(req), 32'ha);
        step(1);
        checkOutput("t3_pre_beats", 32'(beat_cnt[3] - s3), 32'd2);
        step(3);
        checkOutput("t3_done1",     32'(done), 32'h2);
        checkOutput("t3_req3_held", 32'(req),  32'h8);
        checkOutput("t3_held",      32'(beat_cnt[3] - s3), 32'd2);
        step(4);
        checkOutput("t3_done3",     32'(done), 32'h8);
        checkOutput("t3_beats3",    32'(beat_cnt[3] - s3), 32'd5);
        checkOutput("t3_beats1",    32'(beat_cnt[1] - s1), 32'd3);
        checkOutput("t3_starve",    32'(starve), 32'h0);
        step(2);

        // ch2 starved while ch0 holds the grant for 10 beats
        applyStimulus(0, 10);
        applyStimulus(2, 2);
        step(1);
        clearJobs();
        step(7);
        checkOutput("t4_starve_7",   32'(starve), 32'h0);
        step(1);
        checkOutput("t4_starve_8",   32'(starve), 32'h4);
        step(6);
        checkOutput("t4_done2",      32'(done),   32'h4);
        checkOutput("t4_starve_end", 32'(starve), 32'h4);
        step(1);
        checkOutput("t4_ready",      32'(job_ready), 32'hf);
        checkOutput("t4_starve_idle", 32'(starve), 32'h4);
        applyStimulus(2, 1);
        step(1);
        clearJobs();
        checkOutput("t4_starve_clr", 32'(starve), 32'h0);
        step(2);
        checkOutput("t4_done_again", 32'(done),   32'h4);
        step(1);

        // Grant protocol violations
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        arb_en = 1'b0;
        force_gnt = 4'b0011;
        #1;
        checkOutput("t5_multi_beat", 32'(beat), 32'h0);
        step(1);
        checkOutput("t5_multi_err",  32'(gnt_err), 32'h1);
        force_gnt = 4'b0000;
        rst = 1'b0;
        #1;
        checkOutput("t5_err_rst",    32'(gnt_err), 32'h0);
        rst = 1'b1;
        applyStimulus(1, 1);
        step(1);
        clearJobs();
        force_gnt = 4'b0100;
        #1;
        checkOutput("t5_stray_beat", 32'(beat), 32'h0);
        step(1);
        checkOutput("t5_stray_err",  32'(gnt_err), 32'h1);
        checkOutput("t5_stray_req",  32'(req),  32'h2);
        checkOutput("t5_stray_done", 32'(done), 32'h0);
        force_gnt = 4'b0010;
        #1;
        checkOutput("t5_ch1_beat",   32'(beat), 32'h2);
        step(1);
        force_gnt = 4'b0000;
        checkOutput("t5_ch1_done",   32'(done), 32'h2);
        checkOutput("t5_err_sticky", 32'(gnt_err), 32'h1);
        step(1);

        // len 0 ignored, job_valid during WAIT ignored, reset mid-burst
        rst = 1'b0;
        #1;
        rst = 1'b1;
        applyStimulus(0, 0);
        step(1);
        clearJobs();
        checkOutput("t6_len0_req",   32'(req),       32'h0);
        checkOutput("t6_len0_ready", 32'(job_ready), 32'hf);
        step(1);
        checkOutput("t6_len0_done",  32'(done),      32'h0);

        s3 = beat_cnt[3];
        applyStimulus(3, 2);
        step(1);
        checkOutput("t6_wait_req",   32'(req), 32'h8);
        applyStimulus(3, 5);
        step(2);
        clearJobs();
        checkOutput("t6_wait_ready", 32'(job_ready), 32'h7);
        arb_en = 1'b1;
        step(2);
        checkOutput("t6_wait_done",  32'(done), 32'h8);
        checkOutput("t6_wait_beats", 32'(beat_cnt[3] - s3), 32'd2);
        step(1);

        applyStimulus(2, 5);
        step(1);
        clearJobs();
        step(3);
        checkOutput("t6_mid_req",    32'(req), 32'h4);
        rst = 1'b0;
        #1;
        checkOutput("t6_arst_req",   32'(req),       32'h0);
        checkOutput("t6_arst_ready", 32'(job_ready), 32'hf);
        checkOutput("t6_arst_beat",  32'(beat),      32'h0);
        #3;
        rst = 1'b1;
        step(1);
        checkOutput("t6_post_ready", 32'(job_ready), 32'hf);
        checkOutput("t6_post_done",  32'(done),      32'h0);
        checkOutput("t6_post_req",   32'(req),       32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arb_requester_ctrl.md
Name: arb_requester_ctrl

Overview:
- Requester-side front end for the 4-way fixed priority arbiter. It takes per-channel burst jobs, drives `req`, and consumes `gnt`.
- For each channel it holds `req` until the requested number of granted beats completes. It tolerates preemption by higher-priority channels.
- It flags starvation and grant-protocol violations.
- Sits between client logic and the arbiter. `req`/`gnt` connect directly to the arbiter's ports.

Parameters:
- N, 4, number of channels; must match the arbiter width.
- LEN_W, 4, width of burst length. Maximum burst is 2^LEN_W-1 beats.
- TIMEOUT, 8, wait cycles without a first grant before `starve` sets. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- job_valid  in  N  per-channel job submit, sampled at posedge.
- job_len  in  N*LEN_W  burst length per channel; slice i is [i*LEN_W +: LEN_W].
- job_ready  out  N  channel idle and able to accept a job.
- req  out  N  request vector to arbiter, registered.
- gnt  in  N  grant vector from arbiter.
- beat  out  N  combinational; `req & gnt` for active channels; marks one transferred beat.
- done  out  N  registered; one-cycle pulse after a channel's last beat.
- starve  out  N  registered, sticky per job.
- gnt_err  out  1  registered, sticky until reset.

Behaviour:
- Reset (rst=0, asynchronous), applied to all channels:
  - state=IDLE; req=0, done=0, starve=0, gnt_err=0; rem=0, wait_cnt=0.
  - job_ready=all ones, beat=0.
- Per-channel FSM, independent instances: IDLE, WAIT, XFER, DONE.
- IDLE:
  - job_ready[i]=1.
  - On posedge with job_valid[i]=1 and len!=0: latch rem=len, clear wait_cnt and starve[i], go to WAIT. req[i]=1 from the next cycle.
  - len=0: job ignored; stays IDLE, no done.
- WAIT:
  - req[i]=1, job_ready[i]=0.
  - Each posedge with gnt[i]=0: wait_cnt increments, saturating at TIMEOUT. When wait_cnt reaches TIMEOUT, starve[i] sets on that edge. starve is never auto-cleared mid-job.
  - Posedge with gnt[i]=1 is a beat: rem decrements. Next state is DONE if rem was 1, else XFER.
- XFER:
  - req[i]=1. Each posedge with gnt[i]=1 is a beat and decrements rem. On the beat where rem==1, go to DONE.
  - gnt[i]=0 (preempted): hold req, no beat, rem unchanged, wait_cnt not counted.
- DONE:
  - req[i]=0, done[i]=1, job_ready[i]=0 for exactly one cycle, then IDLE.
  - A new job is accepted earliest one cycle after done.
- Latency and throughput:
  - A job of length L with an uncontested registered arbiter: req at cycle 1, first gnt at cycle 2, beats cycles 2..L+1, done at cycle L+2.
  - Beats need not be contiguous.
- beat is defined as `beat[i] = gnt[i] & req[i] & (state==WAIT|XFER)`.
- job_valid outside IDLE is ignored, with no queuing.
- gnt_err sets on any posedge where:
  - gnt has more than one bit set, or
  - `(gnt & ~req) != 0`.
  
  A grant to a non-requester (including a channel in DONE or IDLE) produces no beat and does not change rem.
- Simultaneous jobs on several channels are accepted in the same cycle.
- Reset mid-burst: req drops asynchronously and the job is discarded without done.

Test Plan:
- Reset, then job_valid=4'b0100, len2=3, with an ideal registered fixed-priority arbiter model (bit0 highest) → req=0100 the next cycle; beat[2] on 3 consecutive cycles; done=0100 one cycle after; job_ready[2] back to 1.
- Jobs ch3 len=4 and ch0 len=2 in the same cycle → ch0's 2 beats complete first while ch3 waits; ch3 gets 4 beats afterwards; two done pulses, ch0 before ch3; starve stays 0.
- ch3 mid-burst (2 of 5 beats done) preempted by a ch1 len=3 job → ch3 req held, rem stays 3 during ch1's 3 beats; ch3 then finishes its remaining 3 beats; total beat[3] count is 5.
- ch2 requests while the bench keeps ch0 granted for 10 cycles, TIMEOUT=8 → starve[2]=1 after the 8th ungranted cycle; it remains 1 through the burst; it clears on ch2's next accepted job.
- Bench forces gnt=0011, then separately gnt=0100 with req[2]=0 → gnt_err=1 on each case (checked after reset between); no beat on the non-requesting channel; rem unchanged.
- job with len=0 → ignored, no req. job_valid during WAIT → ignored. rst=0 asserted mid-burst → req=0 immediately; after release, all channels IDLE with job_ready=1111.
